// File: rtl/vga_ctrl_regs_pkg.sv
// vga_pkg: shared constants and types for the VGA control register block.
//   - register addresses on the 2-bit CPU window
//   - graphics mode encodings driven on the mode output
//   - STATUS register bit positions
//   - bus FSM state type
package vga_pkg;

    localparam logic [1:0] ADDR_MODE   = 2'd0;
    localparam logic [1:0] ADDR_PLANE  = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_FRAME  = 2'd3;

    localparam logic [1:0] MODE_TEXT    = 2'd0;
    localparam logic [1:0] MODE_320X200 = 2'd1;
    localparam logic [1:0] MODE_320X400 = 2'd2;
    localparam logic [1:0] MODE_640X200 = 2'd3;

    localparam int STAT_VSYNC_BIT = 0;
    localparam int STAT_FLIP_BIT  = 1;
    localparam int STAT_IRQ_BIT   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        HOLD = 2'd3
    } bus_state_t;

endpackage

// File: rtl/vga_ctrl_regs_if.sv
// vga_ctrl_regs_if: CPU I/O bus into the VGA register window.
//   _io_cs  window select, active low
//   addr    register select A1:A0
//   _rd/_wr read / write strobes, active low
//   din     write data
//   dout    read data, dout_en asks the CPU-side buffer to drive it
// master = CPU side, slave = register block.
interface vga_ctrl_regs_if;
    logic       _io_cs;
    logic [1:0] addr;
    logic       _rd;
    logic       _wr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dout_en;

    modport master (
        output _io_cs, addr, _rd, _wr, din,
        input  dout, dout_en
    );

    modport slave (
        input  _io_cs, addr, _rd, _wr, din,
        output dout, dout_en
    );
endinterface

// File: rtl/vga_ctrl_regs_sync2.sv
// vga_sync2: two-flop synchronizer, parameterized width.
//   clock   destination clock
//   _reset  asynchronous active-low reset, clears both stages to 0
//   d       asynchronous input
//   q       synchronized output, two clocks behind d
module vga_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             _reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/vga_ctrl_regs.sv
// vga_ctrl_regs: CPU-visible control registers for the VGA timing block.
// Holds shadow copies of mode and display plane that are applied on the
// next vsync rising edge, counts frames and raises a vertical-blank irq.
//
// Ports:
//   clock   50 MHz system clock
//   _reset  asynchronous active-low reset
//   bus     CPU register window (vga_ctrl_regs_if.slave)
//   vsync   vertical sync from the timing block, active high
//   mode    active graphics mode (0 text, 1 320x200, 2 320x400, 3 640x200)
//   plane   active display plane
//   irq     vertical-blank interrupt request
//
// Build option: define VGA_IRQ_EN to enable irq_pending, irq and STATUS
// bit2. Without it irq is tied low, STATUS bit2 reads 0 and clears are
// ignored.
//
// Bus FSM states:
//   state | meaning
//   IDLE  | waiting for a synced select with a strobe
//   WR    | single commit cycle for the addressed register
//   RD    | driving read data, held until the CPU ends the cycle
//   HOLD  | write committed, waiting for the CPU to end the cycle
module vga_ctrl_regs
    import vga_pkg::*;
(
    input  logic                  clock,
    input  logic                  _reset,
    vga_ctrl_regs_if.slave        bus,
    input  logic                  vsync,
    output logic [1:0]            mode,
    output logic                  plane,
    output logic                  irq
);

    logic       s_cs;
    logic       s_rd;
    logic       s_wr;
    logic [1:0] s_addr;
    logic       s_vs;

    vga_sync2 #(.WIDTH(5)) u_sync_bus (
        .clock  (clock),
        ._reset (_reset),
        .d      ({bus._io_cs, bus._rd, bus._wr, bus.addr}),
        .q      ({s_cs, s_rd, s_wr, s_addr})
    );

    vga_sync2 #(.WIDTH(1)) u_sync_vs (
        .clock  (clock),
        ._reset (_reset),
        .d      (vsync),
        .q      (s_vs)
    );

    bus_state_t bus_state;
    logic       vs_prev;
    logic       vs_rise;
    logic       armed;
    logic       wr_req;
    logic       rd_req;
    logic       cyc_end;
    logic [7:0] rd_data;

    logic [1:0] shadow_mode;
    logic       shadow_plane;
    logic       flip_pending;
    logic       irq_pending;
    logic [7:0] frame;

    logic       wr_commit;
    logic       wr_mode;
    logic       wr_plane;
    logic       wr_frame;

    // Synchronizer flops reset to 0, which looks like active strobes.
    // armed stays low until both synced strobes have been seen high so a
    // CPU cycle already in flight at reset release is not acted on.
    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            armed   <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            if (s_rd && s_wr) begin
                armed <= 1'b1;
            end
            vs_prev <= s_vs;
        end
    end

    assign vs_rise = s_vs & ~vs_prev;
    assign wr_req  = armed & ~s_cs & ~s_wr;
    assign rd_req  = armed & ~s_cs & ~s_rd;
    assign cyc_end = s_cs | (s_rd & s_wr);

    always_comb begin
        rd_data = 8'h00;
        case (s_addr)
            ADDR_MODE:   rd_data = {6'b0, mode};
            ADDR_PLANE:  rd_data = {7'b0, plane};
            ADDR_STATUS: begin
                rd_data[STAT_IRQ_BIT]   = irq_pending;
                rd_data[STAT_FLIP_BIT]  = flip_pending;
                rd_data[STAT_VSYNC_BIT] = s_vs;
            end
            ADDR_FRAME:  rd_data = frame;
            default:     rd_data = 8'h00;
        endcase
    end

    // Write has priority over read when both strobes are low in IDLE.
    // dout/dout_en are registered alongside the state so they are valid
    // exactly while the FSM sits in RD.
    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            bus_state   <= IDLE;
            bus.dout    <= 8'h00;
            bus.dout_en <= 1'b0;
        end else begin
            case (bus_state)
                IDLE: begin
                    if (wr_req) begin
                        bus_state <= WR;
                    end else if (rd_req) begin
                        bus_state   <= RD;
                        bus.dout_en <= 1'b1;
                        bus.dout    <= rd_data;
                    end
                end
                WR: begin
                    bus_state <= HOLD;
                end
                RD: begin
                    if (cyc_end) begin
                        bus_state   <= IDLE;
                        bus.dout_en <= 1'b0;
                        bus.dout    <= 8'h00;
                    end else begin
                        bus.dout <= rd_data;
                    end
                end
                HOLD: begin
                    if (cyc_end) begin
                        bus_state <= IDLE;
                    end
                end
                default: begin
                    bus_state   <= IDLE;
                    bus.dout_en <= 1'b0;
                    bus.dout    <= 8'h00;
                end
            endcase
        end
    end

    assign wr_commit = (bus_state == WR);
    assign wr_mode   = wr_commit && (s_addr == ADDR_MODE);
    assign wr_plane  = wr_commit && (s_addr == ADDR_PLANE);
    assign wr_frame  = wr_commit && (s_addr == ADDR_FRAME);

    // Non-blocking reads of the shadows mean a write landing on the same
    // cycle as a vsync edge takes effect one frame later; a same-cycle
    // plane write keeps flip_pending set for that reason.
    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            mode         <= MODE_TEXT;
            plane        <= 1'b0;
            shadow_mode  <= MODE_TEXT;
            shadow_plane <= 1'b0;
            flip_pending <= 1'b0;
            frame        <= 8'h00;
        end else begin
            if (wr_mode) begin
                shadow_mode <= bus.din[1:0];
            end
            if (wr_plane) begin
                shadow_plane <= bus.din[0];
            end

            if (wr_plane) begin
                flip_pending <= 1'b1;
            end else if (vs_rise) begin
                flip_pending <= 1'b0;
            end

            if (vs_rise) begin
                mode <= shadow_mode;
                if (flip_pending) begin
                    plane <= shadow_plane;
                end
            end

            if (wr_frame) begin
                frame <= 8'h00;
            end else if (vs_rise) begin
                frame <= frame + 8'd1;
            end
        end
    end

`ifdef VGA_IRQ_EN
    logic wr_status;
    assign wr_status = wr_commit && (s_addr == ADDR_STATUS);

    // Set wins over a same-cycle clear so no frame interrupt is lost.
    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            irq_pending <= 1'b0;
        end else if (vs_rise) begin
            irq_pending <= 1'b1;
        end else if (wr_status && bus.din[STAT_IRQ_BIT]) begin
            irq_pending <= 1'b0;
        end
    end

    assign irq = irq_pending;
`else
    assign irq_pending = 1'b0;
    assign irq         = 1'b0;
`endif

endmodule
